// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: holds the A and B operand
// buffers, clears the PE accumulators, streams skewed rows/columns, then flags done.
module systolic_ctrl #(
    parameter int N = 2,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(N*N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 start,
    output logic [N*WIDTH-1:0]   a_data,
    output logic [N-1:0]         a_valid,
    output logic [N*WIDTH-1:0]   b_data,
    output logic [N-1:0]         b_valid,
    output logic                 array_clr,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(2*N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    a_mem [N*N];
    logic [WIDTH-1:0]    b_mem [N*N];
    logic                wr_in_range;
    logic [N*WIDTH-1:0]  nxt_a_data;
    logic [N*WIDTH-1:0]  nxt_b_data;
    logic [N-1:0]        nxt_a_valid;
    logic [N-1:0]        nxt_b_valid;

    // When N*N is not a power of two the upper addresses have no storage behind them.
    generate
        if (N*N == (1 << AW)) begin : g_full_range
            assign wr_in_range = 1'b1;
        end else begin : g_partial_range
            assign wr_in_range = (wr_addr < AW'(N*N));
        end
    endgenerate

    // Buffers keep their contents across rst; writes are dropped while a run is in flight.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && wr_in_range) begin
            if (wr_sel) begin
                b_mem[wr_addr] <= wr_data;
            end else begin
                a_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Skewed operand slice for the feed step that will be visible after the next edge.
    always_comb begin
        int          feed_t;
        logic [AW-1:0] a_idx;
        logic [AW-1:0] b_idx;
        nxt_a_data  = '0;
        nxt_b_data  = '0;
        nxt_a_valid = '0;
        nxt_b_valid = '0;
        a_idx       = '0;
        b_idx       = '0;
        feed_t      = (state == S_CLEAR) ? 0 : int'(cnt) + 1;
        for (int i = 0; i < N; i++) begin
            if (feed_t >= i && feed_t - i < N) begin
                a_idx = AW'(i*N + feed_t - i);
                nxt_a_valid[i] = 1'b1;
                nxt_a_data[i*WIDTH +: WIDTH] = a_mem[a_idx];
            end
            if (feed_t >= i && feed_t - i < N) begin
                b_idx = AW'((feed_t - i)*N + i);
                nxt_b_valid[i] = 1'b1;
                nxt_b_data[i*WIDTH +: WIDTH] = b_mem[b_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_data    <= '0;
            b_data    <= '0;
            a_valid   <= '0;
            b_valid   <= '0;
            array_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        array_clr <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    array_clr <= 1'b0;
                    cnt       <= '0;
                    state     <= S_FEED;
                    a_data    <= nxt_a_data;
                    b_data    <= nxt_b_data;
                    a_valid   <= nxt_a_valid;
                    b_valid   <= nxt_b_valid;
                end
                S_FEED: begin
                    if (cnt == CW'(2*N-2)) begin
                        state   <= S_DRAIN;
                        cnt     <= '0;
                        a_data  <= '0;
                        b_data  <= '0;
                        a_valid <= '0;
                        b_valid <= '0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        a_data  <= nxt_a_data;
                        b_data  <= nxt_b_data;
                        a_valid <= nxt_a_valid;
                        b_valid <= nxt_b_valid;
                    end
                end
                S_DRAIN: begin
                    // N idle cycles let the last operands reach PE(N-1,N-1).
                    if (cnt == CW'(N-1)) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl at N=2 and N=4: streams are compared against the skew rule,
// and a behavioural PE array fed by the DUT must end up holding A*B.
module tb_systolic_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2, start4, wr_en2, wr_en4, wr_sel;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] a_data2, b_data2;
    logic [1:0]  a_valid2, b_valid2;
    logic        clr2, busy2, done2;
    logic [31:0] a_data4, b_data4;
    logic [3:0]  a_valid4, b_valid4;
    logic        clr4, busy4, done4;

    int sel;
    int checks;
    int errors;
    int memA [2][4][4];
    int memB [2][4][4];
    int cArr [4][4];
    int aReg [4][4];
    int bReg [4][4];
    bit avReg [4][4];
    bit bvReg [4][4];

    logic [31:0] obsA, obsB;
    logic [3:0]  obsAv, obsBv;
    logic        obsClr;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(2), .WIDTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_sel(wr_sel), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .start(start2), .a_data(a_data2), .a_valid(a_valid2),
        .b_data(b_data2), .b_valid(b_valid2), .array_clr(clr2), .busy(busy2), .done(done2)
    );

    systolic_ctrl #(.N(4), .WIDTH(8)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start4), .a_data(a_data4), .a_valid(a_valid4),
        .b_data(b_data4), .b_valid(b_valid4), .array_clr(clr4), .busy(busy4), .done(done4)
    );

    always_comb begin
        if (sel == 0) begin
            obsA = {16'b0, a_data2}; obsB = {16'b0, b_data2};
            obsAv = {2'b0, a_valid2}; obsBv = {2'b0, b_valid2}; obsClr = clr2;
        end else begin
            obsA = a_data4; obsB = b_data4;
            obsAv = a_valid4; obsBv = b_valid4; obsClr = clr4;
        end
    end

    // Behavioural output-stationary PE grid: operands move east/south one PE per cycle.
    always @(negedge clk) begin : peModel
        int nn;
        int ain, bin;
        bit aval, bval;
        nn = (sel == 0) ? 2 : 4;
        if (obsClr) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    cArr[i][j] = 0;
        end
        for (int i = nn - 1; i >= 0; i--) begin
            for (int j = nn - 1; j >= 0; j--) begin
                if (j == 0) begin
                    ain = int'(obsA[i*8 +: 8]); aval = obsAv[i];
                end else begin
                    ain = aReg[i][j-1]; aval = avReg[i][j-1];
                end
                if (i == 0) begin
                    bin = int'(obsB[j*8 +: 8]); bval = obsBv[j];
                end else begin
                    bin = bReg[i-1][j]; bval = bvReg[i-1][j];
                end
                if (aval && bval) cArr[i][j] = cArr[i][j] + ain * bin;
                aReg[i][j] = ain; avReg[i][j] = aval;
                bReg[i][j] = bin; bvReg[i][j] = bval;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setStart(input int s, input logic v);
        if (s == 0) start2 = v; else start4 = v;
    endtask

    task automatic setWrEn(input int s, input logic v);
        if (s == 0) wr_en2 = v; else wr_en4 = v;
    endtask

    task automatic modelWrite(input int s, input bit wsel, input int addr, input int data);
        int nn;
        nn = (s == 0) ? 2 : 4;
        if (wsel) memB[s][addr / nn][addr % nn] = data;
        else      memA[s][addr / nn][addr % nn] = data;
    endtask

    // One host write issued while the DUT is idle, so the model takes it too.
    task automatic applyStimulus(input int s, input bit wsel, input int addr, input int data);
        wr_sel = wsel; wr_addr = 4'(addr); wr_data = 8'(data);
        setWrEn(s, 1'b1);
        modelWrite(s, wsel, addr, data);
        @(negedge clk);
        setWrEn(s, 1'b0);
    endtask

    // k = cycles since the start-accept edge (k=1 is the clear cycle); outside 1..3N+1 = idle.
    task automatic checkCycle(input int s, input int k);
        int nn, t;
        logic [31:0] ea, eb, oa, ob;
        logic [3:0]  eav, ebv, oav, obv;
        logic        eclr, ebusy, edone, oclr, obusy, odone;
        nn = (s == 0) ? 2 : 4;
        ea = '0; eb = '0; eav = '0; ebv = '0;
        eclr  = (k == 1);
        ebusy = (k >= 1 && k <= 3*nn);
        edone = (k == 3*nn + 1);
        if (k >= 2 && k <= 2*nn) begin
            t = k - 2;
            for (int i = 0; i < nn; i++) begin
                if (t - i >= 0 && t - i < nn) begin
                    eav[i] = 1'b1; ea[i*8 +: 8] = 8'(memA[s][i][t-i]);
                    ebv[i] = 1'b1; eb[i*8 +: 8] = 8'(memB[s][t-i][i]);
                end
            end
        end
        if (s == 0) begin
            oa = {16'b0, a_data2}; ob = {16'b0, b_data2}; oav = {2'b0, a_valid2}; obv = {2'b0, b_valid2};
            oclr = clr2; obusy = busy2; odone = done2;
        end else begin
            oa = a_data4; ob = b_data4; oav = a_valid4; obv = b_valid4;
            oclr = clr4; obusy = busy4; odone = done4;
        end
        checkOutput($sformatf("N%0d k%0d a_data", nn, k), 64'(oa), 64'(ea));
        checkOutput($sformatf("N%0d k%0d a_valid", nn, k), 64'(oav), 64'(eav));
        checkOutput($sformatf("N%0d k%0d b_data", nn, k), 64'(ob), 64'(eb));
        checkOutput($sformatf("N%0d k%0d b_valid", nn, k), 64'(obv), 64'(ebv));
        checkOutput($sformatf("N%0d k%0d array_clr", nn, k), 64'(oclr), 64'(eclr));
        checkOutput($sformatf("N%0d k%0d busy", nn, k), 64'(obusy), 64'(ebusy));
        checkOutput($sformatf("N%0d k%0d done", nn, k), 64'(odone), 64'(edone));
    endtask

    task automatic checkC(input int s);
        int nn, sum;
        nn = (s == 0) ? 2 : 4;
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < nn; j++) begin
                sum = 0;
                for (int k = 0; k < nn; k++) sum += memA[s][i][k] * memB[s][k][j];
                checkOutput($sformatf("N%0d C[%0d][%0d]", nn, i, j), 64'(cArr[i][j]), 64'(sum));
            end
        end
    endtask

    // Called at cycle 1 of a run; walks to the first idle cycle after done.
    task automatic runCheck(input int s, input bit holdStart, input bit midWrite, input bit drainStart);
        int nn;
        nn = (s == 0) ? 2 : 4;
        for (int k = 1; k <= 3*nn + 1; k++) begin
            checkCycle(s, k);
            if (midWrite && k == 3) begin
                wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd99;
                setWrEn(s, 1'b1);
            end
            if (drainStart && k == 2*nn + 1) setStart(s, 1'b1);
            @(negedge clk);
            setWrEn(s, 1'b0);
            if (!holdStart) setStart(s, 1'b0);
        end
        checkCycle(s, 3*nn + 2);
        checkC(s);
    endtask

    task automatic beginRun(input int s, input bit holdStart, input bit midWrite,
                            input bit drainStart, input bit wrWithStart);
        int nn, addr, data;
        bit wsel;
        nn = (s == 0) ? 2 : 4;
        sel = s;
        if (wrWithStart) begin
            wsel = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, nn*nn - 1));
            data = int'($urandom_range(0, 255));
            wr_sel = wsel; wr_addr = 4'(addr); wr_data = 8'(data);
            setWrEn(s, 1'b1);
            modelWrite(s, wsel, addr, data);
        end
        setStart(s, 1'b1);
        @(negedge clk);
        setWrEn(s, 1'b0);
        if (!holdStart) setStart(s, 1'b0);
        runCheck(s, holdStart, midWrite, drainStart);
    endtask

    task automatic loadMatrices(input int s, input bit rnd, input int aVal, input int bVal);
        int nn;
        nn = (s == 0) ? 2 : 4;
        for (int a = 0; a < nn*nn; a++) applyStimulus(s, 1'b0, a, rnd ? int'($urandom_range(0, 255)) : aVal);
        for (int a = 0; a < nn*nn; a++) applyStimulus(s, 1'b1, a, rnd ? int'($urandom_range(0, 255)) : bVal);
    endtask

    initial begin
        checks = 0; errors = 0; sel = 0;
        rst = 1'b1; start2 = 1'b0; start4 = 1'b0; wr_en2 = 1'b0; wr_en4 = 1'b0;
        wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    memA[s][i][j] = 0; memB[s][i][j] = 0;
                end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        checkCycle(0, 0);
        checkCycle(1, 0);

        // N=2 worked example, then identity B, then ignored write/start during a run.
        for (int a = 0; a < 4; a++) applyStimulus(0, 1'b0, a, a + 1);
        for (int a = 0; a < 4; a++) applyStimulus(0, 1'b1, a, a + 5);
        beginRun(0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("N2 C00 literal", 64'(cArr[0][0]), 64'd19);
        checkOutput("N2 C11 literal", 64'(cArr[1][1]), 64'd50);
        applyStimulus(0, 1'b1, 0, 1); applyStimulus(0, 1'b1, 1, 0);
        applyStimulus(0, 1'b1, 2, 0); applyStimulus(0, 1'b1, 3, 1);
        beginRun(0, 1'b0, 1'b0, 1'b0, 1'b0);
        beginRun(0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkCycle(0, 0);

        // start held through done relaunches from IDLE on the following edge.
        beginRun(0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        setStart(0, 1'b0);
        runCheck(0, 1'b0, 1'b0, 1'b0);

        // Reset two cycles mid-feed: outputs clear, no done afterwards, buffers kept.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            setStart(s, 1'b1);
            @(negedge clk);
            setStart(s, 1'b0);
            for (int k = 1; k <= 3; k++) begin
                checkCycle(s, k);
                if (k < 3) @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            checkCycle(s, 0);
            @(negedge clk);
            rst = 1'b0;
            checkCycle(s, 0);
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                checkCycle(s, 0);
            end
            if (s == 0) beginRun(0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // N=4 with all-ones A and all-twos B, then random operands on both sizes.
        loadMatrices(1, 1'b0, 1, 2);
        beginRun(1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("N4 C33 literal", 64'(cArr[3][3]), 64'd8);
        for (int r = 0; r < 6; r++) begin
            int s;
            s = r % 2;
            sel = s;
            loadMatrices(s, 1'b1, 0, 0);
            beginRun(s, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
